// File: rtl/pwm_array_pkg.sv
// Shared types and reset constants for the multi-channel PWM generator.
// Enum encodings are fixed so the 1-bit mode input can be cast directly.
package pwm_array_pkg;
  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} cnt_dir_e;

  localparam pwm_mode_e RST_MODE = PWM_EDGE;
  localparam cnt_dir_e  RST_DIR  = DIR_UP;
endpackage

// File: rtl/pwm_timebase.sv
// Common timebase: prescaler, up/up-down counter, boundary detection and
// the shadowed period/mode that change only at a period boundary.
module pwm_timebase
  import pwm_array_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CNT_W-1:0]   i_period,
  input  logic [PRESC_W-1:0] i_prescale,
  input  logic               i_center_mode,
  input  logic               i_load,
  output logic [CNT_W-1:0]   o_cnt,
  output logic               o_boundary,
  output logic               o_period_end,
  output logic               o_load_pending
);
  logic [PRESC_W-1:0] r_presc_cnt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_period_a;
  pwm_mode_e          r_mode_a;
  cnt_dir_e           r_dir;
  logic               r_period_end;
  logic               r_load_pending;
  logic               w_tick;
  logic               w_boundary;
  logic               w_apply;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_tick    = (r_presc_cnt == i_prescale);
  assign w_cnt_inc = r_cnt + 1'b1;

  // A zero period collapses the counter: every tick ends a period.
  always_comb begin
    w_boundary = 1'b0;
    if (w_tick) begin
      if (r_period_a == '0)
        w_boundary = 1'b1;
      else if (r_mode_a == PWM_EDGE)
        w_boundary = (r_cnt == r_period_a);
      else
        w_boundary = (r_dir == DIR_DOWN) && (r_cnt == CNT_W'(1));
    end
  end

  assign w_apply = w_boundary && (r_load_pending || i_load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc_cnt    <= '0;
      r_cnt          <= '0;
      r_period_a     <= '0;
      r_mode_a       <= RST_MODE;
      r_dir          <= RST_DIR;
      r_period_end   <= 1'b0;
      r_load_pending <= 1'b0;
    end else begin
      r_presc_cnt  <= w_tick ? '0 : r_presc_cnt + 1'b1;
      r_period_end <= w_boundary;
      if (w_apply)
        r_load_pending <= 1'b0;
      else if (i_load)
        r_load_pending <= 1'b1;
      if (w_apply) begin
        r_period_a <= i_period;
        r_mode_a   <= pwm_mode_e'(i_center_mode);
      end
      if (w_tick) begin
        if (w_boundary) begin
          r_cnt <= '0;
          r_dir <= DIR_UP;
        end else if (r_mode_a == PWM_EDGE) begin
          r_cnt <= w_cnt_inc;
        end else if (r_dir == DIR_UP) begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == r_period_a)
            r_dir <= DIR_DOWN;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign o_cnt          = r_cnt;
  assign o_boundary     = w_boundary;
  assign o_period_end   = r_period_end;
  assign o_load_pending = r_load_pending;
endmodule

// File: rtl/pwm_array.sv
// Multi-channel PWM: per-channel shadowed duty, compare against the shared
// timebase counter, and a registered enable mux per output pin.
module pwm_array
  import pwm_array_pkg::*;
#(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       i_en_out,
  input  logic [NUM_CH-1:0]       i_en_pwm,
  input  logic [NUM_CH*CNT_W-1:0] i_duty,
  input  logic [CNT_W-1:0]        i_period,
  input  logic [PRESC_W-1:0]      i_prescale,
  input  logic                    i_center_mode,
  input  logic                    i_load,
  output logic [NUM_CH-1:0]       o_out,
  output logic                    o_period_end,
  output logic                    o_load_pending
);
  logic [CNT_W-1:0]  w_cnt;
  logic              w_boundary;
  logic              w_load_pending;
  logic              w_apply;
  logic [NUM_CH-1:0] w_out_next;
  logic [CNT_W-1:0]  r_duty_a [NUM_CH];
  logic [NUM_CH-1:0] r_out;

  pwm_timebase #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_period       (i_period),
    .i_prescale     (i_prescale),
    .i_center_mode  (i_center_mode),
    .i_load         (i_load),
    .o_cnt          (w_cnt),
    .o_boundary     (w_boundary),
    .o_period_end   (o_period_end),
    .o_load_pending (w_load_pending)
  );

  // Same apply condition the timebase uses for period/mode, so all shadows move together.
  assign w_apply = w_boundary && (w_load_pending || i_load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++)
        r_duty_a[i] <= '0;
    end else if (w_apply) begin
      for (int i = 0; i < NUM_CH; i++)
        r_duty_a[i] <= i_duty[i*CNT_W +: CNT_W];
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_out_next[gi] = i_en_out[gi] ? (i_en_pwm[gi] ? (w_cnt < r_duty_a[gi]) : 1'b1) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_out <= '0;
    else
      r_out <= w_out_next;
  end

  assign o_out          = r_out;
  assign o_load_pending = w_load_pending;
endmodule

// File: tb/tb_pwm_array.sv
// Randomised and directed bench for pwm_array with a scoreboard: a
// period-position model predicts every clock, a monitor compares at negedge.
module tb_pwm_array;
  localparam int NUM_CH  = 16;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 4;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH-1:0]       en_out;
  logic [NUM_CH-1:0]       en_pwm;
  logic [NUM_CH*CNT_W-1:0] duty;
  logic [CNT_W-1:0]        period;
  logic [PRESC_W-1:0]      prescale;
  logic                    center_mode;
  logic                    load;
  logic [NUM_CH-1:0]       out;
  logic                    period_end;
  logic                    load_pending;

  pwm_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_en_out       (en_out),
    .i_en_pwm       (en_pwm),
    .i_duty         (duty),
    .i_period       (period),
    .i_prescale     (prescale),
    .i_center_mode  (center_mode),
    .i_load         (load),
    .o_out          (out),
    .o_period_end   (period_end),
    .o_load_pending (load_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0] out;
    logic              pe;
    logic              lp;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference model state: position within the period rather than a counter/direction pair.
  int m_pc, m_phase, m_pa, m_center, m_pend;
  int m_duty[NUM_CH];

  function automatic int m_len();
    if (m_pa == 0) return 1;
    return (m_center != 0) ? 2 * m_pa : m_pa + 1;
  endfunction

  function automatic int m_cnt();
    if (m_center != 0 && m_phase > m_pa) return 2 * m_pa - m_phase;
    return m_phase;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_phase = 0; m_pa = 0; m_center = 0; m_pend = 0;
    for (int i = 0; i < NUM_CH; i++) m_duty[i] = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    exp_t e;
    int   tick, bnd, app, len;
    len  = m_len();
    tick = (m_pc == int'(prescale)) ? 1 : 0;
    for (int i = 0; i < NUM_CH; i++)
      e.out[i] = en_out[i] ? (en_pwm[i] ? (m_cnt() < m_duty[i]) : 1'b1) : 1'b0;
    bnd  = (tick != 0 && m_phase == len - 1) ? 1 : 0;
    app  = (bnd != 0 && (m_pend != 0 || load)) ? 1 : 0;
    e.pe = (bnd != 0);
    if (app != 0) m_pend = 0;
    else if (load) m_pend = 1;
    e.lp = (m_pend != 0);
    m_pc = (tick != 0) ? 0 : (m_pc + 1) % (1 << PRESC_W);
    if (tick != 0) m_phase = (app != 0) ? 0 : (m_phase + 1) % len;
    if (app != 0) begin
      m_pa     = int'(period);
      m_center = int'(center_mode);
      for (int i = 0; i < NUM_CH; i++) m_duty[i] = int'(duty[i*CNT_W +: CNT_W]);
    end
    exp_q.push_back(e);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out", 32'(out), 32'(e.out));
        chk("period_end", 32'(period_end), 32'(e.pe));
        chk("load_pending", 32'(load_pending), 32'(e.lp));
      end
    end
  end

  task automatic set_duty(input int ch, input int v);
    duty[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic pulse_load();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic config_tb(input int p, input int ps, input int cm);
    period      = CNT_W'(p);
    prescale    = PRESC_W'(ps);
    center_mode = (cm != 0);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; en_out = '0; en_pwm = '0; duty = '0;
    config_tb(0, 0, 0);
    run(3);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_period_end", 32'(period_end), 32'd0);
    chk("rst_load_pending", 32'(load_pending), 32'd0);
    rst_n = 1'b1;

    // Edge mode, 3/10 and 7/10 duties.
    config_tb(9, 0, 0);
    set_duty(0, 3); set_duty(5, 7);
    en_out = '1; en_pwm = '1;
    pulse_load();
    run(40);

    // Extremes and enable handling.
    set_duty(0, 0); set_duty(1, 10);
    pulse_load();
    run(25);
    en_pwm[2] = 1'b0; run(5);
    en_out[2] = 1'b0; run(5);

    // Shadow behaviour: duty change without load, then load mid-period.
    set_duty(0, 3); pulse_load(); run(20);
    set_duty(0, 7); run(25);
    pulse_load(); run(30);

    // Mid-period asynchronous reset with outputs toggling.
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_period_end", 32'(period_end), 32'd0);
    chk("mid_rst_load_pending", 32'(load_pending), 32'd0);
    run(2);
    rst_n = 1'b1;
    run(15);

    // Center mode.
    config_tb(4, 1, 1);
    set_duty(0, 2);
    pulse_load();
    run(60);

    // Prescaler and load coinciding with boundaries.
    config_tb(1, 3, 0);
    pulse_load();
    run(20);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk) load = 1'b1;
      @(negedge clk) load = 1'b0;
      run(k);
    end
    run(20);

    // Randomised configurations, live prescale changes and load timing.
    for (int it = 0; it < 40; it++) begin
      int p;
      p = $urandom_range(0, 12);
      config_tb(p, $urandom_range(0, 3), $urandom_range(0, 1));
      for (int i = 0; i < NUM_CH; i++) set_duty(i, $urandom_range(0, p + 2));
      if ($urandom_range(0, 9) == 0) set_duty($urandom_range(0, NUM_CH - 1), 255);
      en_out = NUM_CH'($urandom); en_pwm = NUM_CH'($urandom);
      if ($urandom_range(0, 3) != 0) pulse_load();
      run($urandom_range(5, 60));
      if ($urandom_range(0, 4) == 0) begin
        prescale = PRESC_W'($urandom_range(0, 15));
        run($urandom_range(5, 40));
      end
    end

    run(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
